// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Word-addressed data/instruction memory for the multicycle ARM datapath.
// A request is taken in IDLE. The memory then waits a fixed LATENCY and
// answers with a one-cycle ready pulse. Misaligned and out-of-range accesses
// are reported on err instead of wrapping onto a valid word.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   req    - request strobe, sampled only in IDLE
//   we     - 1 = write, 0 = read, sampled with req
//   addr   - byte address, sampled with req
//   wdata  - write data, sampled with req
//   rdata  - registered read data, holds the last successful read
//   ready  - one-cycle completion pulse
//   err    - access error, valid only while ready = 1
//   busy   - high whenever the responder is not in IDLE
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             err,
    output logic             busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The counter only has to hold LATENCY-1, so it needs at least one bit.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         counter;
    logic                  lat_we;
    logic [31:0]           lat_addr;
    logic [WIDTH-1:0]      lat_wdata;
    logic [WIDTH-1:0]      mem [0:DEPTH-1];

    logic                  access_now;
    logic                  acc_err;
    logic                  mem_wr;
    logic [DEPTH_LOG2-1:0] word_idx;

    // The access fires on the edge that leaves WAIT. Checks use the latched
    // address, so the master may change addr after it has been accepted.
    // An address with any bit set above the array is an error rather than
    // an alias of a low word. The reset term keeps an aborted request from
    // writing while reset is held.
    always_comb begin
        access_now = (state == ST_WAIT) && (counter == '0);
        acc_err    = (lat_addr[1:0] != 2'b00) ||
                     ((lat_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
        mem_wr     = access_now && lat_we && !acc_err && !reset;
        word_idx   = lat_addr[DEPTH_LOG2+1:2];
    end

    // The memory array has no reset, so its power-up contents are undefined.
    // It is written only by a valid write on the WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[word_idx] <= wdata_hold(lat_wdata);
        end
    end

    // Control FSM, request latches and registered outputs.
    // IDLE latches the request and loads the latency counter.
    // WAIT counts down, then performs the access and raises ready.
    // RESP holds ready for its single cycle and then returns to IDLE.
    // A req seen during RESP is ignored and can only be taken in IDLE.
    // busy is registered next to state so that it always equals state != IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            counter   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        counter   <= CNT_LOAD;
                        state     <= ST_WAIT;
                        busy      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        state <= ST_RESP;
                        ready <= 1'b1;
                        err   <= acc_err;
                        if (!acc_err && !lat_we) begin
                            rdata <= mem[word_idx];
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Identity pass-through. It keeps the array write port to a single
    // named data source.
    function automatic logic [WIDTH-1:0] wdata_hold(input logic [WIDTH-1:0] d);
        return d;
    endfunction

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder with LATENCY=2 and DEPTH_LOG2=6.
// A table of directed transactions carries hand-computed expected err and
// rdata values. Hand-written sequences then cover held req, reset during
// WAIT, reset during RESP, and input changes during WAIT.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    mem_responder #(.WIDTH(32), .DEPTH_LOG2(6), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step one cycle. Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Run one request and check latency, err, rdata and the pulse shape.
    // After acceptance the inputs are scrambled to show they are ignored.
    task automatic applyStimulus(input vec_t v);
        int n;
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        tick();
        req   = 1'b0;
        we    = ~v.we;
        addr  = 32'h0000_0040;
        wdata = ~v.wdata;
        checkOutput({v.name, " busy_wait"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput({v.name, " latency"}, n, 32'd3);
        checkOutput({v.name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
        checkOutput({v.name, " rdata"}, rdata, v.exp_rdata);
        tick();
        checkOutput({v.name, " ready_drop"}, {31'd0, ready}, 32'd0);
        checkOutput({v.name, " busy_drop"}, {31'd0, busy}, 32'd0);
        checkOutput({v.name, " err_drop"}, {31'd0, err}, 32'd0);
    endtask

    function automatic vec_t mk(input string name, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic e, input logic [31:0] r);
        vec_t v;
        v.name = name; v.we = w; v.addr = a; v.wdata = d;
        v.exp_err = e; v.exp_rdata = r;
        return v;
    endfunction

    initial begin
        vec_t v;

        // The expected rdata column follows the value held from the last
        // successful read.
        vecs.push_back(mk("wr10",    1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0));
        vecs.push_back(mk("rd10",    1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF));
        vecs.push_back(mk("wr12mis", 1'b1, 32'h12,   32'h12345678, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk("rd10b",   1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF));
        vecs.push_back(mk("wrFC",    1'b1, 32'hFC,   32'hCAFEF00D, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk("rd100oor",1'b0, 32'h100,  32'h0,        1'b1, 32'hDEADBEEF));
        vecs.push_back(mk("rdFC",    1'b0, 32'hFC,   32'h0,        1'b0, 32'hCAFEF00D));
        vecs.push_back(mk("wr20",    1'b1, 32'h20,   32'h11111111, 1'b0, 32'hCAFEF00D));
        vecs.push_back(mk("rd20",    1'b0, 32'h20,   32'h0,        1'b0, 32'h11111111));
        vecs.push_back(mk("rd1010oor",1'b0,32'h1010, 32'h0,        1'b1, 32'h11111111));
        vecs.push_back(mk("wr1010oor",1'b1,32'h1010, 32'h99999999, 1'b1, 32'h11111111));
        vecs.push_back(mk("wr04",    1'b1, 32'h04,   32'h55AA55AA, 1'b0, 32'h11111111));
        vecs.push_back(mk("rd04",    1'b0, 32'h04,   32'h0,        1'b0, 32'h55AA55AA));
        vecs.push_back(mk("rd13mis", 1'b0, 32'h13,   32'h0,        1'b1, 32'h55AA55AA));
        vecs.push_back(mk("rd10c",   1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF));

        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst ready", {31'd0, ready}, 32'd0);
        checkOutput("rst err",   {31'd0, err},   32'd0);
        checkOutput("rst busy",  {31'd0, busy},  32'd0);
        checkOutput("rst rdata", rdata,          32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // With req held high, accepts happen every 4 cycles and ready comes
        // up in cycles 3, 7 and 11.
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 12) req = 1'b0;
            checkOutput($sformatf("held ready c%0d", n), {31'd0, ready},
                        {31'd0, (n % 4) == 3});
            checkOutput($sformatf("held busy c%0d", n), {31'd0, busy},
                        {31'd0, (n % 4) != 0});
            if ((n % 4) == 3) checkOutput("held rdata", rdata, 32'hDEADBEEF);
        end
        tick();
        checkOutput("held final busy", {31'd0, busy}, 32'd0);

        // A reset in the first WAIT cycle aborts the write to 0x20.
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAAAAAA;
        tick();
        req = 1'b0;
        checkOutput("abort busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort busy_now", {31'd0, busy}, 32'd0);
        checkOutput("abort ready_now", {31'd0, ready}, 32'd0);
        tick();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checkOutput("abort no_ready", {31'd0, ready}, 32'd0);
        end
        v = mk("rd20_after_abort", 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111);
        applyStimulus(v);

        // A reset in RESP clears ready at once. The committed write to 0x08
        // must still be in the array afterwards.
        req = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'h77777777;
        tick();
        req = 1'b0;
        tick();
        tick();
        checkOutput("resp ready_pre", {31'd0, ready}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("resp ready_now", {31'd0, ready}, 32'd0);
        checkOutput("resp err_now",   {31'd0, err},   32'd0);
        tick();
        reset = 1'b0;
        tick();
        v = mk("rd08_after_resp_rst", 1'b0, 32'h08, 32'h0, 1'b0, 32'h77777777);
        applyStimulus(v);

        // Changing we/addr/wdata during WAIT has no effect on the read that
        // was already accepted.
        req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0;
        tick();
        req = 1'b0; we = 1'b1; addr = 32'h20; wdata = 32'hBAD0BAD0;
        tick();
        tick();
        checkOutput("chg ready", {31'd0, ready}, 32'd1);
        checkOutput("chg err",   {31'd0, err},   32'd0);
        checkOutput("chg rdata", rdata,          32'hDEADBEEF);
        tick();
        v = mk("rd20_after_chg", 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111);
        applyStimulus(v);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
